// File: rtl/vit_pkg.sv
// Shared constants and helpers for the K=7, rate-1/2 (171/133 octal) Viterbi codec.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package vit_pkg;

    localparam int K          = 7;
    localparam int MEM        = K - 1;
    localparam int NUM_STATES = 1 << MEM;
    localparam logic [K-1:0] G0 = 7'o171;
    localparam logic [K-1:0] G1 = 7'o133;
    localparam int TAIL_LEN   = MEM;
    localparam int TAIL_CNT_W = 3;

    typedef enum logic {
        RUN  = 1'b0,
        TAIL = 1'b1
    } enc_state_e;

    // Generator MSB taps the current bit u, lower taps walk back through s[0]..s[MEM-1].
    function automatic logic [1:0] conv_pair(input logic [MEM-1:0] s, input logic u);
        logic [K-1:0] win;
        win[K-1] = u;
        for (int i = 0; i < MEM; i++) begin
            win[MEM-1-i] = s[i];
        end
        return {^(win & G0), ^(win & G1)};
    endfunction

endpackage

// File: rtl/conv_enc.sv
// Rate-1/2 K=7 convolutional encoder; optional 6-pair zero tail per frame under CONV_ENC_TAIL_EN.
// Latency: coded pair is registered 1 cycle after the information bit is accepted.
// Backpressure: output register holds while out_valid && !out_ready; in_ready drops whenever it cannot drain.
module conv_enc
    import vit_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_bit,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [1:0] out_pair,
    output logic       out_last
);

    logic [MEM-1:0] s_q, s_d;
    logic           out_valid_q, out_valid_d;
    logic [1:0]     out_pair_q, out_pair_d;
    logic           out_last_q, out_last_d;
    logic           rdy_en_q;
    logic           out_free;
    logic           in_fire;
    logic [1:0]     enc_pair;

`ifdef CONV_ENC_TAIL_EN
    enc_state_e            state_q, state_d;
    logic [TAIL_CNT_W-1:0] tail_cnt_q, tail_cnt_d;
    logic                  tail_step;
    logic                  tail_done;
`endif

    // Output register may take a new pair when empty or being drained this cycle.
    assign out_free = !out_valid_q || out_ready;

`ifdef CONV_ENC_TAIL_EN
    assign in_ready  = rdy_en_q && (state_q == RUN) && out_free;
    assign tail_step = (state_q == TAIL) && out_free;
    assign tail_done = (tail_cnt_q == TAIL_CNT_W'(TAIL_LEN - 1));
    assign enc_pair  = conv_pair(s_q, (state_q == RUN) ? in_bit : 1'b0);
`else
    assign in_ready  = rdy_en_q && out_free;
    assign enc_pair  = conv_pair(s_q, in_bit);
`endif

    assign in_fire   = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_pair  = out_pair_q;
    assign out_last  = out_last_q;

    always_comb begin
        s_d         = s_q;
        out_valid_d = out_valid_q;
        out_pair_d  = out_pair_q;
        out_last_d  = out_last_q;
`ifdef CONV_ENC_TAIL_EN
        state_d     = state_q;
        tail_cnt_d  = tail_cnt_q;
`endif
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (in_fire) begin
            out_valid_d = 1'b1;
            out_pair_d  = enc_pair;
            s_d         = {s_q[MEM-2:0], in_bit};
`ifdef CONV_ENC_TAIL_EN
            out_last_d  = 1'b0;
            if (in_last) begin
                state_d    = TAIL;
                tail_cnt_d = '0;
            end
`else
            out_last_d  = in_last;
            if (in_last) begin
                s_d = '0;
            end
`endif
        end
`ifdef CONV_ENC_TAIL_EN
        else if (tail_step) begin
            // Flush the register with zeros; the final flush pair closes the frame.
            out_valid_d = 1'b1;
            out_pair_d  = enc_pair;
            out_last_d  = tail_done;
            s_d         = {s_q[MEM-2:0], 1'b0};
            tail_cnt_d  = tail_cnt_q + TAIL_CNT_W'(1);
            if (tail_done) begin
                state_d    = RUN;
                tail_cnt_d = '0;
                s_d        = '0;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_q    <= 1'b0;
            s_q         <= '0;
            out_valid_q <= 1'b0;
            out_pair_q  <= 2'b00;
            out_last_q  <= 1'b0;
`ifdef CONV_ENC_TAIL_EN
            state_q     <= RUN;
            tail_cnt_q  <= '0;
`endif
        end else begin
            rdy_en_q    <= 1'b1;
            s_q         <= s_d;
            out_valid_q <= out_valid_d;
            out_pair_q  <= out_pair_d;
            out_last_q  <= out_last_d;
`ifdef CONV_ENC_TAIL_EN
            state_q     <= state_d;
            tail_cnt_q  <= tail_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_conv_enc.sv
// Self-checking bench for conv_enc: directed frames plus random frames against a convolution model.
module tb_conv_enc;

`ifdef CONV_ENC_TAIL_EN
    localparam bit TAIL_ON = 1'b1;
`else
    localparam bit TAIL_ON = 1'b0;
`endif
    localparam int G0_OCT = 'o171;
    localparam int G1_OCT = 'o133;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       in_bit;
    logic       in_last;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [1:0] out_pair;
    logic       out_last;

    conv_enc dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_bit   (in_bit),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pair (out_pair),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    int         vec_cnt = 0;
    int         err_cnt = 0;
    int         cyc = 0;
    int         rdy_mode = 0;
    bit         gaps = 1'b0;
    logic [2:0] exp_q[$];
    int         xfer_cyc[$];
    bit         frame_bits[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom);
            endcase
        end
    end

    // Output monitor: ordering, stall stability and 1-cycle latency.
    bit         prev_stall = 1'b0;
    bit         pend_lat = 1'b0;
    logic [1:0] held_pair;
    logic       held_last;
    logic [2:0] e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            pend_lat   = 1'b0;
        end else begin
            if (pend_lat) check_eq("latency", out_valid, 1);
            if (prev_stall) begin
                check_eq("stall_valid", out_valid, 1);
                check_eq("stall_pair", out_pair, held_pair);
                check_eq("stall_last", out_last, held_last);
            end
            if (out_valid && out_ready) begin
                check_eq("pair_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("pair", out_pair, e[2:1]);
                    check_eq("last", out_last, e[0]);
                    xfer_cyc.push_back(cyc);
                end
            end
            prev_stall = out_valid && !out_ready;
            held_pair  = out_pair;
            held_last  = out_last;
            pend_lat   = in_valid && in_ready;
        end
    end

    // Reference: each frame is convolved from an all-zero history, zero-padded when the tail is on.
    task automatic model_frame();
        int n = frame_bits.size();
        int total = n + (TAIL_ON ? 6 : 0);
        int x[$];
        for (int t = 0; t < total; t++) x.push_back((t < n) ? int'(frame_bits[t]) : 0);
        for (int t = 0; t < total; t++) begin
            int a = 0;
            int b = 0;
            for (int j = 0; j < 7; j++) begin
                if (t - j >= 0) begin
                    a ^= ((G0_OCT >> (6 - j)) & 1) & x[t-j];
                    b ^= ((G1_OCT >> (6 - j)) & 1) & x[t-j];
                end
            end
            exp_q.push_back({a[0], b[0], (t == total - 1)});
        end
    endtask

    task automatic send_frame(input bit use_model);
        int n = frame_bits.size();
        bit acc;
        if (use_model) model_frame();
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_bit   = 1'($urandom);
                in_last  = 1'($urandom);
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_bit   = frame_bits[i];
            in_last  = (i == n - 1);
            acc = 1'b0;
            for (int c = 0; c < 200 && !acc; c++) begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
            end
            check_eq("accept", acc, 1);
        end
        in_valid = 1'b0;
        in_bit   = 1'($urandom);
        in_last  = 1'($urandom);
    endtask

    task automatic drain();
        int c = 0;
        while (exp_q.size() != 0 && c < 1000) begin
            @(posedge clk);
            c++;
        end
        repeat (3) @(posedge clk);
        #1;
        check_eq("drain", exp_q.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cnt;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_bit = 1'b0;
        in_last = 1'b0;
        #12;
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_pair", out_pair, 0);
        check_eq("rst_last", out_last, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rdy_after_rst", in_ready, 1);

`ifdef CONV_ENC_TAIL_EN
        // Impulse with tail: 11,10,11,11,00,01,11 back to back, last on 7th.
        frame_bits = {1'b1};
        exp_q.push_back(3'b110); exp_q.push_back(3'b100); exp_q.push_back(3'b110);
        exp_q.push_back(3'b110); exp_q.push_back(3'b000); exp_q.push_back(3'b010);
        exp_q.push_back(3'b111);
        xfer_cyc.delete();
        send_frame(1'b0);
        drain();
        check_eq("imp_count", xfer_cyc.size(), 7);
        if (xfer_cyc.size() == 7) check_eq("imp_span", xfer_cyc[6] - xfer_cyc[0], 6);

        // Ten zeros: 16 zero pairs, input blocked for the 6 tail cycles.
        frame_bits.delete();
        for (int i = 0; i < 10; i++) frame_bits.push_back(1'b0);
        send_frame(1'b1);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (in_ready) break;
            cnt++;
        end
        check_eq("tail_busy", cnt, 6);
        drain();
`else
        // Tail off, 1,0,1: pairs 11,10,00 with last on the third.
        frame_bits = {1'b1, 1'b0, 1'b1};
        exp_q.push_back(3'b110); exp_q.push_back(3'b100); exp_q.push_back(3'b001);
        send_frame(1'b0);
        drain();
`endif

        // Back-to-back one-bit frames: each must start from state 0.
        frame_bits = {1'b1};
        send_frame(1'b1);
        send_frame(1'b1);
        drain();

        // 32 random bits with out_ready toggling every cycle.
        rdy_mode = 1;
        frame_bits.delete();
        for (int i = 0; i < 32; i++) frame_bits.push_back(1'($urandom));
        send_frame(1'b1);
        drain();

        for (int f = 0; f < 12; f++) begin
            rdy_mode = f % 3;
            gaps = f[0];
            frame_bits.delete();
            cnt = $urandom_range(1, 20);
            for (int i = 0; i < cnt; i++) frame_bits.push_back(1'($urandom));
            send_frame(1'b1);
            if ($urandom_range(0, 1) == 1) drain();
        end
        rdy_mode = 0;
        gaps = 1'b0;
        drain();

        // Reset in the middle of a frame (third tail cycle when the tail is on).
`ifdef CONV_ENC_TAIL_EN
        frame_bits = {1'b1};
        send_frame(1'b1);
        @(posedge clk);
        @(posedge clk);
`else
        exp_q.push_back(3'b110); exp_q.push_back(3'b010);
        in_valid = 1'b1;
        in_bit = 1'b1;
        in_last = 1'b0;
        @(posedge clk);
        @(posedge clk);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", out_valid, 0);
        check_eq("midrst_pair", out_pair, 0);
        check_eq("midrst_last", out_last, 0);
        exp_q.delete();
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midrst_rdy", in_ready, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_eq("no_stale_pair", out_valid, 0);
        end
        @(posedge clk);
        #1;
        frame_bits = {1'b1, 1'b1, 1'b0, 1'b1};
        send_frame(1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
